int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-002 The block SHALL expose: irq  in  4  peripheral requests (irq[0] highest priority).
REQ-003 The block SHALL expose: n_iorq, n_m1, n_rd, n_wr  in  1 each  registered CPU bus strobes, active-low.
REQ-004 The block SHALL expose: addr  in  16  CPU address (only addr[7:0] decoded); wdata  in  8  CPU write data.
REQ-005 The block SHALL expose: rdata  out  8  data to CPU; rdata_en  out  1  rdata valid; n_int  out  1  maskable interrupt request to CPU, active-low.

Function
REQ-006 The block SHALL decode IO ports (n_iorq=0, n_m1=1): BASE+0 MASK (R/W, bits[3:0], 1=enabled); BASE+1 PEND (R; W1C); BASE+2 VBASE (R/W, bits[7:3]); BASE+3 EOI (W, data ignored); BASE+4 ISR (R, bits[3:0]).
REQ-007 The block SHALL commit a write only on the first cycle of n_wr low (n_wr low now, high the previous cycle), so a multi-cycle strobe writes once.
REQ-008 The block SHALL drive rdata/rdata_en combinationally while n_iorq=0, n_rd=0, n_m1=1 and addr[7:0] matches; otherwise rdata=0, rdata_en=0; unused register bits SHALL read 0.
REQ-009 Level mode: pend[i] SHALL be set on each clock edge where irq[i]=1.
REQ-010 A set event and a W1C clear of the same pend bit in one cycle SHALL leave the bit set.
REQ-011 The block SHALL let source i win only if pend[i]&mask[i]=1 and no isr bit j<=i is set; the lowest such index wins.
REQ-012 n_int SHALL be registered: low the cycle after a winner exists, high the cycle after none exists.
REQ-013 The block SHALL detect acknowledge as n_m1=0 and n_iorq=0; on the first ack cycle it SHALL latch the vector, clear pend[winner], set isr[winner], and force n_int high the next cycle.
REQ-014 The vector SHALL be {VBASE[7:3], idx[1:0], 1'b0}; with no winner at ack (spurious), the vector SHALL be {VBASE[7:3], 3'b111} and isr SHALL be unchanged.
REQ-015 The block SHALL hold the latched vector on rdata with rdata_en=1 for every cycle the ack persists.
REQ-016 An EOI write SHALL clear the lowest-index set isr bit; EOI with isr=0 SHALL have no effect.
REQ-017 Masking a pending source SHALL not clear pend; unmasking SHALL re-raise n_int per REQ-012.

Reset
REQ-018 Reset SHALL make mask=0, pend=0, isr=0, VBASE=0, the latched vector 0 and the write-edge and irq-history registers idle (n_wr history high, irq history 0); n_int=1, rdata=0, rdata_en=0.
REQ-019 Reset asserted mid-ack or mid-write SHALL take effect on that clock edge, and the operation SHALL not complete.

Configuration
REQ-020 With INT_CTRL_EDGE_EN defined, pend[i] SHALL be set only on a 0->1 transition of irq[i] against its registered previous value; without it, level mode (REQ-009) SHALL apply.

Structure
REQ-021 The shared package SHALL hold INT_CTRL_BASE (8'hF0), the register offsets, INT_CTRL_NSRC (4) and the spurious vector low bits (3'b111).
REQ-022 The winner selection SHALL be a combinational sub-module int_prio_enc (inputs pend, mask, isr; outputs valid, idx[1:0]).

Verification
REQ-023 Bench: write MASK=0x0F, VBASE=0x40, pulse irq[2] -> n_int low within 2 cycles; ack cycle -> rdata=0x44, rdata_en=1; n_int high the next cycle; ISR reads 0x04.
REQ-024 Bench: irq[1] and irq[3] pending, both enabled -> first ack returns VBASE|0x02; EOI -> second ack returns VBASE|0x06; ISR reads 0 after the second EOI.
REQ-025 Bench: irq[0] while isr[2]=1 -> n_int low (preempts); irq[3] while isr[2]=1 -> n_int stays high until EOI.
REQ-026 Bench: write PEND=0x01 in the same cycle irq[0]=1 -> PEND reads 0x01; 3-cycle n_wr low writing MASK -> written once.
REQ-027 Bench: ack with mask=0 -> rdata=VBASE|0x07 and ISR unchanged; reset mid-ack -> n_int=1 and MASK, PEND, ISR all read 0.
REQ-028 Bench, INT_CTRL_EDGE_EN defined: irq[1] held high across a W1C of PEND bit 1 -> bit stays clear; irq[1] 0->1 -> bit set.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared constants, register map and vector helper for the int_ctrl interrupt controller.
package int_ctrl_pkg;

  localparam int         INT_CTRL_NSRC    = 4;
  localparam logic [7:0] INT_CTRL_BASE    = 8'hF0;
  localparam logic [7:0] INT_CTRL_OFS_MASK  = 8'd0;
  localparam logic [7:0] INT_CTRL_OFS_PEND  = 8'd1;
  localparam logic [7:0] INT_CTRL_OFS_VBASE = 8'd2;
  localparam logic [7:0] INT_CTRL_OFS_EOI   = 8'd3;
  localparam logic [7:0] INT_CTRL_OFS_ISR   = 8'd4;
  localparam logic [2:0] INT_CTRL_SPUR_LO = 3'b111;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MASK,
    REG_PEND,
    REG_VBASE,
    REG_EOI,
    REG_ISR
  } reg_sel_e;

  function automatic reg_sel_e reg_decode(input logic [7:0] a);
    reg_sel_e sel;
    case (a)
      INT_CTRL_BASE + INT_CTRL_OFS_MASK:  sel = REG_MASK;
      INT_CTRL_BASE + INT_CTRL_OFS_PEND:  sel = REG_PEND;
      INT_CTRL_BASE + INT_CTRL_OFS_VBASE: sel = REG_VBASE;
      INT_CTRL_BASE + INT_CTRL_OFS_EOI:   sel = REG_EOI;
      INT_CTRL_BASE + INT_CTRL_OFS_ISR:   sel = REG_ISR;
      default:                            sel = REG_NONE;
    endcase
    return sel;
  endfunction

  // Spurious acks still carry VBASE so the CPU lands in a known handler slot.
  function automatic logic [7:0] make_vec(input logic [4:0] vbase, input logic valid,
                                          input logic [1:0] idx);
    return valid ? {vbase, idx, 1'b0} : {vbase, INT_CTRL_SPUR_LO};
  endfunction

endpackage

// File: rtl/int_ctrl_prio.sv
// int_prio_enc: combinational winner select; a source is blocked by any in-service bit at or above its priority.
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [INT_CTRL_NSRC-1:0] pend,
  input  logic [INT_CTRL_NSRC-1:0] mask,
  input  logic [INT_CTRL_NSRC-1:0] isr,
  output logic                     valid,
  output logic [1:0]               idx
);

  logic blocked;

  always_comb begin
    valid   = 1'b0;
    idx     = 2'd0;
    blocked = 1'b0;
    for (int i = 0; i < INT_CTRL_NSRC; i++) begin
      blocked = blocked | isr[i];
      if (!valid && !blocked && pend[i] && mask[i]) begin
        valid = 1'b1;
        idx   = i[1:0];
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: 4-source vectored interrupt controller on a Z80-style IO bus.
// Define INT_CTRL_EDGE_EN for rising-edge request capture; default is level capture.
module int_ctrl
  import int_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq,
  input  logic        n_iorq,
  input  logic        n_m1,
  input  logic        n_rd,
  input  logic        n_wr,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rdata_en,
  output logic        n_int
);

  logic [3:0] mask, pend, isr;
  logic [4:0] vbase;
  logic [7:0] vec;
  logic       wr_hist, ack_hist;

  logic       valid;
  logic [1:0] idx;
  reg_sel_e   sel;
  logic       io_cyc, ack, ack_first, ack_take, wr_stb;
  logic [3:0] set_ev, win_oh, eoi_clr, w1c, pend_nxt, isr_nxt;
  logic [7:0] vec_now;
  logic       unused_addr_hi;

  assign unused_addr_hi = ^addr[15:8];

  int_prio_enc u_prio (
    .pend (pend),
    .mask (mask),
    .isr  (isr),
    .valid(valid),
    .idx  (idx)
  );

  assign sel       = reg_decode(addr[7:0]);
  assign io_cyc    = !n_iorq && n_m1;
  assign ack       = !n_iorq && !n_m1;
  assign ack_first = ack && !ack_hist;
  assign ack_take  = ack_first && valid;
  assign wr_stb    = io_cyc && !n_wr && wr_hist;
  assign vec_now   = make_vec(vbase, valid, idx);
  assign win_oh    = ack_take ? (4'b0001 << idx) : 4'b0000;
  assign eoi_clr   = (wr_stb && sel == REG_EOI) ? (isr & (~isr + 4'd1)) : 4'b0000;
  assign w1c       = (wr_stb && sel == REG_PEND) ? wdata[3:0] : 4'b0000;

`ifdef INT_CTRL_EDGE_EN
  logic [3:0] irq_hist;

  always_ff @(posedge clk) begin
    if (reset) irq_hist <= 4'b0000;
    else       irq_hist <= irq;
  end

  assign set_ev = irq & ~irq_hist;
`else
  assign set_ev = irq;
`endif

  // New requests are OR-ed in last so a same-cycle set beats W1C or ack clear.
  assign pend_nxt = (pend & ~w1c & ~win_oh) | set_ev;
  assign isr_nxt  = (isr & ~eoi_clr) | win_oh;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask     <= 4'b0000;
      pend     <= 4'b0000;
      isr      <= 4'b0000;
      vbase    <= 5'd0;
      vec      <= 8'h00;
      wr_hist  <= 1'b1;
      ack_hist <= 1'b0;
      n_int    <= 1'b1;
    end else begin
      pend     <= pend_nxt;
      isr      <= isr_nxt;
      wr_hist  <= n_wr;
      ack_hist <= ack;
      n_int    <= ack_first ? 1'b1 : !valid;
      if (wr_stb && sel == REG_MASK)  mask  <= wdata[3:0];
      if (wr_stb && sel == REG_VBASE) vbase <= wdata[7:3];
      if (ack_first)                  vec   <= vec_now;
    end
  end

  // First ack cycle bypasses the latch so the vector is valid immediately.
  always_comb begin
    rdata    = 8'h00;
    rdata_en = 1'b0;
    if (ack) begin
      rdata_en = 1'b1;
      rdata    = ack_first ? vec_now : vec;
    end else if (io_cyc && !n_rd) begin
      case (sel)
        REG_MASK:  begin rdata_en = 1'b1; rdata = {4'b0000, mask}; end
        REG_PEND:  begin rdata_en = 1'b1; rdata = {4'b0000, pend}; end
        REG_VBASE: begin rdata_en = 1'b1; rdata = {vbase, 3'b000}; end
        REG_ISR:   begin rdata_en = 1'b1; rdata = {4'b0000, isr};  end
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus random bus traffic against a behavioural model.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic        n_iorq, n_m1, n_rd, n_wr;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_en;
  logic        n_int;

  int_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .n_iorq  (n_iorq),
    .n_m1    (n_m1),
    .n_rd    (n_rd),
    .n_wr    (n_wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .rdata_en(rdata_en),
    .n_int   (n_int)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  bit [3:0] m_mask, m_pend, m_isr, m_irq_prev;
  bit [4:0] m_vbase;
  bit [7:0] m_vec;
  bit       m_nint, m_nwr_prev, m_ack_prev;
  logic [7:0] last_rd;

  function automatic int m_winner();
    for (int i = 0; i < 4; i++) begin
      if (m_pend[i] && m_mask[i]) begin
        bit blk = 1'b0;
        for (int j = 0; j <= i; j++) if (m_isr[j]) blk = 1'b1;
        if (!blk) return i;
      end
    end
    return -1;
  endfunction

  function automatic int m_reg(input logic [7:0] a);
    int d = int'(a) - 240;
    return (d >= 0 && d <= 4) ? d : -1;
  endfunction

  function automatic logic [7:0] m_vec_of(input int w);
    if (w >= 0) return {m_vbase, w[1:0], 1'b0};
    return {m_vbase, 3'b111};
  endfunction

  // One clock: check combinational read path, clock, update model, check n_int.
  task automatic step();
    logic [7:0] er;
    logic       ee;
    int         w, r;
    bit         ackc, ackf, wr, done;
    bit [3:0]   set_ev, np, ni;
    w    = m_winner();
    r    = m_reg(addr[7:0]);
    ackc = !n_m1 && !n_iorq;
    ackf = ackc && !m_ack_prev;
    er = 8'h00; ee = 1'b0;
    if (ackc) begin
      ee = 1'b1;
      er = ackf ? m_vec_of(w) : m_vec;
    end else if (!n_iorq && n_m1 && !n_rd) begin
      case (r)
        0: begin ee = 1'b1; er = {4'b0, m_mask};  end
        1: begin ee = 1'b1; er = {4'b0, m_pend};  end
        2: begin ee = 1'b1; er = {m_vbase, 3'b0}; end
        4: begin ee = 1'b1; er = {4'b0, m_isr};   end
        default: ;
      endcase
    end
    #1;
    check("rdata", rdata, er);
    check("rdata_en", rdata_en, ee);
    last_rd = rdata;
    @(posedge clk);
    if (reset) begin
      m_mask = 0; m_pend = 0; m_isr = 0; m_vbase = 0; m_vec = 0;
      m_nint = 1; m_nwr_prev = 1; m_ack_prev = 0; m_irq_prev = 0;
    end else begin
      wr = !n_iorq && n_m1 && !n_wr && m_nwr_prev;
`ifdef INT_CTRL_EDGE_EN
      set_ev = irq & ~m_irq_prev;
`else
      set_ev = irq;
`endif
      np = m_pend; ni = m_isr;
      if (wr && r == 1) np = np & ~wdata[3:0];
      if (ackf && w >= 0) begin np[w] = 1'b0; ni[w] = 1'b1; end
      if (wr && r == 3) begin
        done = 1'b0;
        for (int i = 0; i < 4; i++)
          if (!done && m_isr[i]) begin ni[i] = 1'b0; done = 1'b1; end
      end
      np = np | set_ev;
      if (ackf) m_vec = m_vec_of(w);
      if (wr && r == 0) m_mask = wdata[3:0];
      if (wr && r == 2) m_vbase = wdata[7:3];
      m_nint = ackf ? 1'b1 : (w < 0);
      m_pend = np; m_isr = ni;
      m_nwr_prev = n_wr; m_ack_prev = ackc; m_irq_prev = irq;
    end
    #1;
    check("n_int", n_int, m_nint);
    @(negedge clk);
  endtask

  task automatic bus_idle();
    n_iorq = 1'b1; n_m1 = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
  endtask

  task automatic set_addr(input int off);
    addr = {8'($urandom_range(255)), 8'(240 + off)};
  endtask

  task automatic io_wr(input int off, input logic [7:0] d);
    set_addr(off); wdata = d; n_iorq = 1'b0; n_wr = 1'b0;
    step();
    bus_idle();
    step();
  endtask

  task automatic io_rd(input int off, output logic [7:0] d);
    set_addr(off); n_iorq = 1'b0; n_rd = 1'b0;
    step();
    d = last_rd;
    bus_idle();
    step();
  endtask

  task automatic do_ack(input int n, output logic [7:0] v);
    n_iorq = 1'b0; n_m1 = 1'b0;
    step();
    v = last_rd;
    repeat (n - 1) step();
    bus_idle();
    step();
  endtask

  task automatic pulse(input logic [3:0] p);
    irq = p; step(); irq = 4'b0; step();
  endtask

  logic [7:0] v;

  initial begin
    bus_idle(); irq = 4'b0; addr = 16'h0; wdata = 8'h0; reset = 1'b1;
    @(negedge clk);
    step(); step();
    reset = 1'b0;
    check("rst_n_int", n_int, 1'b1);
    io_rd(0, v); check("rst_mask", v, 8'h00);
    io_rd(1, v); check("rst_pend", v, 8'h00);
    io_rd(2, v); check("rst_vbase", v, 8'h00);
    io_rd(4, v); check("rst_isr", v, 8'h00);

    // Basic vectored ack
    io_wr(0, 8'h0F); io_wr(2, 8'h40);
    pulse(4'b0100);
    check("t1_n_int_low", n_int, 1'b0);
    do_ack(1, v); check("t1_vec", v, 8'h44);
    check("t1_n_int_high", n_int, 1'b1);
    io_rd(4, v); check("t1_isr", v, 8'h04);
    io_wr(3, 8'h00);

    // Two pending, served in priority order
    pulse(4'b1010);
    do_ack(2, v); check("t2_vec1", v, 8'h42);
    io_wr(3, 8'h00);
    do_ack(1, v); check("t2_vec3", v, 8'h46);
    io_wr(3, 8'h00);
    io_rd(4, v); check("t2_isr_clear", v, 8'h00);

    // Preemption by higher priority, blocking of lower priority
    pulse(4'b0100);
    do_ack(1, v); check("t3_vec2", v, 8'h44);
    pulse(4'b0001);
    check("t3_preempt", n_int, 1'b0);
    do_ack(1, v); check("t3_vec0", v, 8'h40);
    io_wr(3, 8'h00);
    pulse(4'b1000); step();
    check("t3_blocked", n_int, 1'b1);
    io_wr(3, 8'h00);
    check("t3_after_eoi", n_int, 1'b0);
    do_ack(1, v); check("t3_vec3", v, 8'h46);
    io_wr(3, 8'h00);

    // Set beats W1C; multi-cycle write commits once
    io_wr(1, 8'h0F);
    irq = 4'b0001; set_addr(1); wdata = 8'h01; n_iorq = 1'b0; n_wr = 1'b0;
    step();
    irq = 4'b0000; bus_idle();
    step();
    io_rd(1, v); check("t4_set_wins", v, 8'h01);
    io_wr(1, 8'h01);
    set_addr(0); n_iorq = 1'b0; n_wr = 1'b0;
    wdata = 8'h03; step();
    wdata = 8'h0C; step();
    wdata = 8'h0A; step();
    bus_idle(); step();
    io_rd(0, v); check("t4_write_once", v, 8'h03);

    // Spurious ack, then reset in the middle of an ack
    io_wr(0, 8'h00);
    pulse(4'b0010);
    do_ack(1, v); check("t5_spurious", v, 8'h47);
    io_rd(4, v); check("t5_isr_kept", v, 8'h00);
    io_rd(1, v); check("t5_pend_kept", v, 8'h02);
    io_wr(0, 8'h0F);
    n_iorq = 1'b0; n_m1 = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; bus_idle();
    step();
    check("t5_rst_n_int", n_int, 1'b1);
    io_rd(0, v); check("t5_rst_mask", v, 8'h00);
    io_rd(1, v); check("t5_rst_pend", v, 8'h00);
    io_rd(4, v); check("t5_rst_isr", v, 8'h00);

    // Held request across W1C
    irq = 4'b0010; step();
    io_wr(1, 8'h02);
`ifdef INT_CTRL_EDGE_EN
    io_rd(1, v); check("t6_edge_held", v, 8'h00);
    irq = 4'b0000; step();
    irq = 4'b0010; step();
    io_rd(1, v); check("t6_edge_rise", v, 8'h02);
`else
    io_rd(1, v); check("t6_level_held", v, 8'h02);
`endif
    irq = 4'b0000;
    io_wr(1, 8'h0F);

    // Random traffic against the model
    for (int it = 0; it < 600; it++) begin
      irq = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0;
      case ($urandom_range(9))
        0, 1, 2: step();
        3, 4: begin
          set_addr($urandom_range(4)); n_iorq = 1'b0; n_wr = 1'b0;
          repeat ($urandom_range(1, 3)) begin
            wdata = 8'($urandom);
            step();
          end
          bus_idle(); step();
        end
        5, 6: io_rd($urandom_range(6), v);
        7: do_ack($urandom_range(1, 2), v);
        8: io_wr(3, 8'($urandom));
        default: begin
          reset = ($urandom_range(15) == 0);
          step();
          reset = 1'b0;
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
